// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker for the 4-bit Fibonacci LFSR stream.
// Locks after N fill beats plus LOCK_CNT matches, then free-runs.
module prbs_checker #(
    parameter int N          = 4,
    parameter int TAP_A      = 1,
    parameter int TAP_B      = 2,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             error_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int FW = $clog2(N + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    localparam logic [FW-1:0] FILL_V   = FW'(N);
    localparam logic [MW-1:0] LOCK_V   = MW'(LOCK_CNT);
    localparam logic [UW-1:0] UNLOCK_V = UW'(UNLOCK_CNT);

    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state;
    logic [N-1:0]     shadow;
    logic [FW-1:0]    fill;
    logic [MW-1:0]    match;
    logic [UW-1:0]    miss;
    logic             error_q;
    logic [CNT_W-1:0] err_cnt;

    logic pred;
    logic mismatch;
    logic hit_err;
    logic filled;

    assign pred     = shadow[TAP_A] ^ shadow[TAP_B];
    assign mismatch = data_i ^ pred;
    assign hit_err  = valid_i && (state == LOCKED) && mismatch;
    assign filled   = (fill == FILL_V);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SEARCH;
            shadow  <= '0;
            fill    <= '0;
            match   <= '0;
            miss    <= '0;
            error_q <= 1'b0;
            err_cnt <= '0;
        end else begin
            error_q <= hit_err;

            // clear wins first, then a coincident error is counted
            if (clear_i)
                err_cnt <= hit_err ? CNT_W'(1) : '0;
            else if (hit_err && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;

            if (valid_i) begin
                case (state)
                    SEARCH: begin
                        shadow <= {shadow[N-2:0], data_i};
                        if (!filled) begin
                            fill <= fill + 1'b1;
                        end else if (!mismatch && (shadow != '0)) begin
                            if ((match + 1'b1) == LOCK_V) begin
                                state <= LOCKED;
                                match <= '0;
                            end else begin
                                match <= match + 1'b1;
                            end
                        end else begin
                            match <= '0;
                        end
                    end
                    default: begin
                        // free-run so received errors never corrupt the reference
                        shadow <= {shadow[N-2:0], pred};
                        if (mismatch) begin
                            if ((miss + 1'b1) == UNLOCK_V) begin
                                state <= SEARCH;
                                fill  <= '0;
                                match <= '0;
                                miss  <= '0;
                            end else begin
                                miss <= miss + 1'b1;
                            end
                        end else begin
                            miss <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign locked_o  = (state == LOCKED);
    assign error_o   = error_q;
    assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, errors, unlock, saturation,
// clear, stuck-zero, gapped input and asynchronous reset.
module tb_prbs_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       data;
    logic       valid;
    logic       clear;
    logic       locked;
    logic       error;
    logic [3:0] err_cnt;
    logic       locked_hi;
    logic       error_hi;
    logic [3:0] err_cnt_hi;

    int passed = 0;
    int total  = 0;
    int any_err;
    int any_lock;
    logic [3:0] g;
    logic       b;

    prbs_checker u_dut (
        .clk       (clk),
        .reset     (reset),
        .data_i    (data),
        .valid_i   (valid),
        .clear_i   (clear),
        .locked_o  (locked),
        .error_o   (error),
        .err_cnt_o (err_cnt)
    );

    prbs_checker #(.UNLOCK_CNT(32)) u_hi (
        .clk       (clk),
        .reset     (reset),
        .data_i    (data),
        .valid_i   (valid),
        .clear_i   (clear),
        .locked_o  (locked_hi),
        .error_o   (error_hi),
        .err_cnt_o (err_cnt_hi)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d",
                    tag, obs, exp);
    endtask

    // reference generator: seed 0001, taps 1/2, new bit at bit0
    task automatic gen();
        g = {g[2:0], g[1] ^ g[2]};
        b = g[0];
    endtask

    // drive at negedge, outputs sampled at the following negedge
    task automatic step(input logic d, input logic v, input logic c);
        data  = d;
        valid = v;
        clear = c;
        @(negedge clk);
        if (error)  any_err++;
        if (locked) any_lock++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        g = 4'b0001;
    endtask

    initial begin
        reset = 1'b0;
        data  = 1'b0;
        valid = 1'b0;
        clear = 1'b0;
        g     = 4'b0001;
        b     = 1'b0;
        #1;
        check("rst_locked", 32'(locked), 0);
        check("rst_error", 32'(error), 0);
        check("rst_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        // lock acquisition
        any_err = 0;
        for (int i = 1; i <= 11; i++) begin
            gen();
            step(b, 1'b1, 1'b0);
        end
        check("lock_b11", 32'(locked), 0);
        gen();
        step(b, 1'b1, 1'b0);
        check("lock_b12", 32'(locked), 1);
        check("lock_cnt", 32'(err_cnt), 0);
        check("lock_noerr", 32'(any_err), 0);
        check("lock_hi", 32'(locked_hi), 1);

        // single-bit error
        gen();
        step(~b, 1'b1, 1'b0);
        check("se_pulse", 32'(error), 1);
        check("se_cnt", 32'(err_cnt), 1);
        check("se_locked", 32'(locked), 1);
        gen();
        step(b, 1'b1, 1'b0);
        check("se_pulse_end", 32'(error), 0);
        any_err = 0;
        for (int i = 0; i < 6; i++) begin
            gen();
            step(b, 1'b1, 1'b0);
        end
        check("se_after", 32'(any_err), 0);
        check("se_cnt_hold", 32'(err_cnt), 1);

        // hold with valid low
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("hold_locked", 32'(locked), 1);
        check("hold_cnt", 32'(err_cnt), 1);

        // clear on a clean beat
        gen();
        step(b, 1'b1, 1'b1);
        check("clr_clean", 32'(err_cnt), 0);

        // loss of lock: three consecutive inverted bits
        gen();
        step(~b, 1'b1, 1'b0);
        gen();
        step(~b, 1'b1, 1'b0);
        check("lol_2nd_locked", 32'(locked), 1);
        gen();
        step(~b, 1'b1, 1'b0);
        check("lol_locked", 32'(locked), 0);
        check("lol_cnt", 32'(err_cnt), 3);
        check("lol_pulse", 32'(error), 1);
        check("lol_hi_locked", 32'(locked_hi), 1);
        check("lol_hi_cnt", 32'(err_cnt_hi), 3);
        any_err = 0;
        for (int i = 1; i <= 11; i++) begin
            gen();
            step(b, 1'b1, 1'b0);
        end
        check("relock_b11", 32'(locked), 0);
        gen();
        step(b, 1'b1, 1'b0);
        check("relock_b12", 32'(locked), 1);
        check("relock_noerr", 32'(any_err), 0);

        // saturation with isolated errors
        for (int i = 0; i < 20; i++) begin
            gen();
            step(~b, 1'b1, 1'b0);
            gen();
            step(b, 1'b1, 1'b0);
        end
        check("sat_cnt", 32'(err_cnt), 15);
        check("sat_hi_cnt", 32'(err_cnt_hi), 15);
        check("sat_locked", 32'(locked), 1);
        gen();
        step(b, 1'b1, 1'b1);
        check("sat_clear", 32'(err_cnt), 0);
        check("sat_hi_clear", 32'(err_cnt_hi), 0);
        gen();
        step(~b, 1'b1, 1'b1);
        check("clr_with_err", 32'(err_cnt), 1);
        check("clr_with_err_p", 32'(error), 1);

        // build err_cnt = 5, ending on an error beat
        for (int i = 0; i < 4; i++) begin
            gen();
            step(b, 1'b1, 1'b0);
            gen();
            step(~b, 1'b1, 1'b0);
        end
        check("pre_rst_cnt", 32'(err_cnt), 5);
        check("pre_rst_err", 32'(error), 1);

        // async reset between edges
        #2;
        reset = 1'b0;
        #1;
        check("arst_locked", 32'(locked), 0);
        check("arst_error", 32'(error), 0);
        check("arst_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        // stuck-zero stream
        any_lock = 0;
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0);
        check("stuck0_nolock", 32'(any_lock), 0);

        // gapped stream
        do_reset();
        any_err = 0;
        for (int i = 1; i <= 11; i++) begin
            gen();
            step(b, 1'b1, 1'b0);
            step(~b, 1'b0, 1'b0);
        end
        check("gap_b11", 32'(locked), 0);
        gen();
        step(b, 1'b1, 1'b0);
        check("gap_b12", 32'(locked), 1);
        step(~b, 1'b0, 1'b0);
        check("gap_hold", 32'(locked), 1);
        check("gap_noerr", 32'(any_err), 0);
        check("gap_cnt", 32'(err_cnt), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
